// File: rtl/uart_echo_fifo_if.sv
// rtl/uart_echo_fifo_if.sv - serial-side and status signals of the UART echo endpoint
interface uart_echo_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int LW = $clog2(DEPTH + 1);

  logic          rx;
  logic          hold;
  logic          tx;
  logic          err;
  logic          ovf;
  logic [LW-1:0] level;

  modport master (output rx, hold, input tx, err, ovf, level);
  modport slave  (input rx, hold, output tx, err, ovf, level);
endinterface

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - UART loopback that echoes received frames through a FIFO
// Optional UART_ECHO_UPCASE_EN folds a..z to A..Z when a byte is loaded for transmit.
module uart_echo_fifo #(
  parameter int DIV_RATIO = 868,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_echo_fifo_if.slave bus
);
  localparam int CW = $clog2(DIV_RATIO);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_RATIO - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV_RATIO / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] FULL      = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic                 rx_s1, rx_s2, rx_d;
  state_t               rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bits;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_half, rx_tick;
  logic                 push_req, err_q;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr, rptr;
  logic [LW-1:0]        level_q;
  logic                 full, do_push, pop, ovf_q;

  state_t               tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bits;
  logic [DATA_BITS-1:0] tx_sh, head, load_data;
  logic                 tx_tick, tx_q;

  // rx_d lags the synchronised line so a start needs a genuine high-to-low edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_half = (rx_cnt == HALF_LAST);
  assign rx_tick = (rx_cnt == DIV_LAST);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_d && !rx_s2) rx_next = S_START;
      S_START: if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bits == BIT_LAST) rx_next = S_STOP;
      S_STOP:  if (rx_tick) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_sh    <= '0;
      push_req <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rx_state <= rx_next;
      push_req <= 1'b0;
      if (rx_state == S_IDLE || rx_next != rx_state || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == S_START) rx_bits <= '0;
      if (rx_state == S_DATA && rx_tick) begin
        rx_sh   <= {rx_s2, rx_sh[DATA_BITS-1:1]};
        rx_bits <= rx_bits + 1'b1;
      end
      if (rx_state == S_STOP && rx_tick) begin
        if (rx_s2) push_req <= 1'b1;
        else       err_q    <= 1'b1;
      end
    end
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign full    = (level_q == FULL);
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_req && full && !pop) ovf_q <= 1'b1;
      case ({do_push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= rx_sh;
  end

  assign head = mem[rptr];

`ifdef UART_ECHO_UPCASE_EN
  generate
    if (DATA_BITS == 8) begin : g_upcase
      always_comb begin
        load_data = head;
        if (head >= 8'h61 && head <= 8'h7A) load_data = head & 8'hDF;
      end
    end else begin : g_raw
      assign load_data = head;
    end
  endgenerate
`else
  assign load_data = head;
`endif

  assign tx_tick = (tx_cnt == DIV_LAST);

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        if (level_q != '0 && !bus.hold) begin
          pop     = 1'b1;
          tx_next = S_START;
        end
      end
      S_START: if (tx_tick) tx_next = S_DATA;
      S_DATA:  if (tx_tick && tx_bits == BIT_LAST) tx_next = S_STOP;
      S_STOP:  if (tx_tick) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  // tx_q is a registered copy of the current bit, so the line trails the FSM by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 1'b1;
      if (pop) begin
        tx_sh   <= load_data;
        tx_bits <= '0;
      end else if (tx_state == S_DATA && tx_tick) begin
        tx_sh   <= tx_sh >> 1;
        tx_bits <= tx_bits + 1'b1;
      end
      case (tx_state)
        S_START: tx_q <= 1'b0;
        S_DATA:  tx_q <= tx_sh[0];
        default: tx_q <= 1'b1;
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.err   = err_q;
  assign bus.ovf   = ovf_q;
  assign bus.level = level_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb/tb_uart_echo_fifo.sv - self-checking bench for uart_echo_fifo (DIV_RATIO=16, DEPTH=4)
module tb_uart_echo_fifo;
  localparam int D   = 16;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_echo_fifo_if #(.DEPTH(DEP)) bus ();

  uart_echo_fifo #(.DIV_RATIO(D), .DATA_BITS(8), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       has_echo;
    logic [7:0] echo;
    logic       err;
  } vec_t;

  vec_t       vt [7];
  logic [7:0] got_q [$];
  int         got_t [$];
  int         got_run [$];
  logic [7:0] exp_q [$];
  int         mon_bad = 0;
  int         tx_low_cnt = 0;
  int         lvl_up_cyc = -1;
  logic [2:0] prev_lvl = '0;

  int         m_cnt, m_t0, m_run;
  bit         m_busy = 0, m_inrun;
  logic [7:0] m_sh;

  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent line decoder: mid-bit sampling from the first low half-cycle
  always @(negedge clk) begin
    if (rst && bus.level == 3'd1 && prev_lvl == 3'd0) lvl_up_cyc = cyc;
    prev_lvl = bus.level;
    if (rst && bus.tx === 1'b0) tx_low_cnt++;
    if (!rst) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (bus.tx === 1'b0) begin
        m_busy = 1; m_cnt = 0; m_t0 = cyc; m_run = 1; m_inrun = 1; m_sh = '0;
      end
    end else begin
      m_cnt++;
      if (m_inrun) begin
        if (bus.tx === 1'b0) m_run++;
        else m_inrun = 0;
      end
      if (m_cnt % D == D / 2) begin
        if (m_cnt / D == 0) begin
          if (bus.tx !== 1'b0) m_busy = 0;
        end else if (m_cnt / D <= 8) begin
          m_sh[m_cnt / D - 1] = bus.tx;
        end else begin
          if (bus.tx === 1'b1) begin
            got_q.push_back(m_sh); got_t.push_back(m_t0); got_run.push_back(m_run);
          end else begin
            mon_bad++;
          end
          m_busy = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (D) @(negedge clk);
    end
    bus.rx = stop;
    repeat (D) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h00, 1'b1, 1'b1, echo_of(8'h00), 1'b0};
    vt[1] = '{8'hFF, 1'b1, 1'b1, echo_of(8'hFF), 1'b0};
    vt[2] = '{8'h61, 1'b1, 1'b1, echo_of(8'h61), 1'b0};
    vt[3] = '{8'h7B, 1'b1, 1'b1, echo_of(8'h7B), 1'b0};
    vt[4] = '{8'h5A, 1'b1, 1'b1, echo_of(8'h5A), 1'b0};
    vt[5] = '{8'hFF, 1'b0, 1'b0, 8'h00,          1'b1};
    vt[6] = '{8'hA3, 1'b1, 1'b1, echo_of(8'hA3), 1'b1};

    bus.rx = 1'b1;
    bus.hold = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_tx", bus.tx, 1);
    chk("reset_err", bus.err, 0);
    chk("reset_ovf", bus.ovf, 0);
    chk("reset_level", bus.level, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    got_q.delete(); got_t.delete(); got_run.delete();
    lvl_up_cyc = -1;
    send(8'h55, 1'b1);
    wait_frames(1, 20 * D);
    chk("t55_count", got_q.size(), 1);
    chk("t55_level_rose", lvl_up_cyc >= 0, 1);
    if (got_q.size() > 0) begin
      chk("t55_byte", got_q[0], 8'h55);
      chk("t55_latency", got_t[0] - lvl_up_cyc, 2);
      chk("t55_start_len", got_run[0], D);
    end
    repeat (2 * D) @(negedge clk);
    chk("t55_level_end", bus.level, 0);
    chk("t55_err", bus.err, 0);
    chk("t55_ovf", bus.ovf, 0);

    got_q.delete();
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx = 1'b1;
    repeat (4 * D) @(negedge clk);
    chk("glitch_level", bus.level, 0);
    chk("glitch_err", bus.err, 0);
    chk("glitch_tx", got_q.size(), 0);

    for (int v = 0; v < 7; v++) begin
      got_q.delete();
      send(vt[v].data, vt[v].stop);
      if (vt[v].has_echo) begin
        wait_frames(1, 20 * D);
        chk($sformatf("vec%0d_count", v), got_q.size(), 1);
        if (got_q.size() > 0) chk($sformatf("vec%0d_byte", v), got_q[0], vt[v].echo);
      end else begin
        repeat (20 * D) @(negedge clk);
        chk($sformatf("vec%0d_count", v), got_q.size(), 0);
        chk($sformatf("vec%0d_level", v), bus.level, 0);
      end
      chk($sformatf("vec%0d_err", v), bus.err, vt[v].err);
    end

    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(echo_of(b));
      send(b, 1'b1);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_frames(12, 30 * D);
    chk("rand_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
    repeat (2 * D) @(negedge clk);
    chk("rand_level", bus.level, 0);
    chk("rand_ovf", bus.ovf, 0);
    chk("rand_err_sticky", bus.err, 1);

    got_q.delete(); got_t.delete();
    bus.hold = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      send(n[7:0], 1'b1);
      repeat (4) @(negedge clk);
      chk($sformatf("hold_level%0d", n), bus.level, (n < DEP) ? n : DEP);
      chk($sformatf("hold_ovf%0d", n), bus.ovf, (n > DEP) ? 1 : 0);
    end
    chk("hold_no_tx", got_q.size(), 0);
    bus.hold = 1'b0;
    wait_frames(DEP, 6 * 11 * D);
    repeat (12 * D) @(negedge clk);
    chk("drain_count", got_q.size(), DEP);
    for (int i = 0; i < DEP && i < got_q.size(); i++) begin
      chk($sformatf("drain_byte%0d", i), got_q[i], i + 1);
      if (i > 0) chk($sformatf("drain_gap%0d", i), got_t[i] - got_t[i-1], 10 * D + 1);
    end
    chk("drain_level", bus.level, 0);

    bus.hold = 1'b1;
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
    repeat (4) @(negedge clk);
    chk("pre_rst_level3", bus.level, 3);
    bus.hold = 1'b0;
    for (int i = 0; i < 50 && bus.level != 3'd2; i++) @(negedge clk);
    chk("pre_rst_level2", bus.level, 2);
    repeat (3 * D + D / 2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ovf", bus.ovf, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    tx_low_cnt = 0;
    repeat (40 * D) @(negedge clk);
    chk("post_rst_frames", got_q.size(), 0);
    chk("post_rst_tx_low", tx_low_cnt, 0);
    chk("post_rst_level", bus.level, 0);
    chk("mon_bad_stop", mon_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
